significand_product_resolver: RTL and testbench

SIGNIFICAND_PRODUCT_RESOLVER -- requirements
Module: significand_product_resolver

---
 rtl/significand_product_resolver.sv | 150 +++++++++++++++
 tb/tb_significand_product_resolver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/significand_product_resolver.sv
// Resolves a carry-save significand product into a normalized, round-to-nearest-even
// significand through a 3-stage pipeline sharing one advance enable.
module significand_product_resolver #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH+1:0]   in_sum,
    input  logic [2*WIDTH+1:0]   in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sig,
    output logic [1:0]           out_exp_inc,
    output logic                 out_zero,
    output logic                 out_inexact,
    output logic                 out_err
);
    localparam int W = WIDTH;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1: low half addition; the upper halves travel untouched with the carry.
    logic [W+1:0] lo_add;
    assign lo_add = {1'b0, in_sum[W:0]} + {1'b0, in_carry[W:0]};

    logic         s1_valid_reg;
    logic         s1_cy_reg;
    logic [W:0]   s1_lo_reg;
    logic [W:0]   s1_sum_hi_reg;
    logic [W:0]   s1_car_hi_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_reg <= 1'b0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s1_lo_reg     <= lo_add[W:0];
            s1_cy_reg     <= lo_add[W+1];
            s1_sum_hi_reg <= in_sum[2*W+1:W+1];
            s1_car_hi_reg <= in_carry[2*W+1:W+1];
        end
    end

    // Stage 2: finish the addition and normalize.
    logic [W:0]     hi_add;
    logic [2*W+1:0] prod;
    assign hi_add = s1_sum_hi_reg + s1_car_hi_reg + {{W{1'b0}}, s1_cy_reg};
    assign prod   = {hi_add, s1_lo_reg};

    logic [W-1:0] norm_sig_next;
    logic         guard_next;
    logic         sticky_next;
    logic         norm_next;
    logic         zero_next;
    logic         err_next;

    always_comb begin
        norm_sig_next = prod[2*W-2:W-1];
        guard_next    = prod[W-2];
        sticky_next   = |prod[W-3:0];
        norm_next     = 1'b0;
        if (prod[2*W-1]) begin
            norm_sig_next = prod[2*W-1:W];
            guard_next    = prod[W-1];
            sticky_next   = |prod[W-2:0];
            norm_next     = 1'b1;
        end
        zero_next = ~|prod[2*W-1:0];
        err_next  = |prod[2*W+1:2*W];
    end

    logic         s2_valid_reg;
    logic [W-1:0] s2_sig_reg;
    logic         s2_guard_reg;
    logic         s2_sticky_reg;
    logic         s2_norm_reg;
    logic         s2_zero_reg;
    logic         s2_err_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid_reg <= 1'b0;
        end else if (adv) begin
            s2_valid_reg  <= s1_valid_reg;
            s2_sig_reg    <= norm_sig_next;
            s2_guard_reg  <= guard_next;
            s2_sticky_reg <= sticky_next;
            s2_norm_reg   <= norm_next;
            s2_zero_reg   <= zero_next;
            s2_err_reg    <= err_next;
        end
    end

    // Stage 3: round to nearest even; a carry out of the increment means all-ones rolled over.
    logic         round_up;
    logic [W:0]   sig_inc;
    logic         ovf;
    logic [W-1:0] sig_next;
    logic [1:0]   exp_inc_next;

    always_comb begin
        round_up     = s2_guard_reg & (s2_sticky_reg | s2_sig_reg[0]);
        sig_inc      = {1'b0, s2_sig_reg} + {{W{1'b0}}, round_up};
        ovf          = sig_inc[W];
        sig_next     = ovf ? {1'b1, {(W-1){1'b0}}} : sig_inc[W-1:0];
        exp_inc_next = {1'b0, s2_norm_reg} + {1'b0, ovf};
    end

    logic         out_valid_reg;
    logic [W-1:0] out_sig_reg;
    logic [1:0]   out_exp_inc_reg;
    logic         out_zero_reg;
    logic         out_inexact_reg;
    logic         out_err_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_reg   <= 1'b0;
            out_sig_reg     <= '0;
            out_exp_inc_reg <= 2'd0;
            out_zero_reg    <= 1'b0;
            out_inexact_reg <= 1'b0;
            out_err_reg     <= 1'b0;
        end else if (adv) begin
            out_valid_reg   <= s2_valid_reg;
            out_err_reg     <= s2_err_reg;
            out_zero_reg    <= s2_zero_reg;
            if (s2_zero_reg) begin
                out_sig_reg     <= '0;
                out_exp_inc_reg <= 2'd0;
                out_inexact_reg <= 1'b0;
            end else begin
                out_sig_reg     <= sig_next;
                out_exp_inc_reg <= exp_inc_next;
                out_inexact_reg <= s2_guard_reg | s2_sticky_reg;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_sig     = out_sig_reg;
    assign out_exp_inc = out_exp_inc_reg;
    assign out_zero    = out_zero_reg;
    assign out_inexact = out_inexact_reg;
    assign out_err     = out_err_reg;
endmodule

// File: tb/tb_significand_product_resolver.sv
// Self-checking bench for significand_product_resolver (WIDTH=8) with an arithmetic reference model.
module tb_significand_product_resolver;
    localparam int W = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [17:0] in_sum = '0;
    logic [17:0] in_carry = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_sig;
    logic [1:0]  out_exp_inc;
    logic        out_zero;
    logic        out_inexact;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    significand_product_resolver #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sig(out_sig), .out_exp_inc(out_exp_inc),
        .out_zero(out_zero), .out_inexact(out_inexact), .out_err(out_err)
    );

    always #5 CLK = ~CLK;

    // Result packing: {sig[7:0], exp_inc[1:0], zero, inexact, err}
    function automatic logic [12:0] observed();
        return {out_sig, out_exp_inc, out_zero, out_inexact, out_err};
    endfunction

    // Reference: integer arithmetic on the product value, rounding by remainder comparison.
    function automatic logic [12:0] model(input logic [17:0] s, input logic [17:0] c);
        int unsigned p, pl, sig, rem, half, norm, ovf, e;
        logic err;
        p   = (int'(s) + int'(c)) % 262144;
        pl  = p % 65536;
        err = (p >= 65536);
        if (pl == 0) return {8'h00, 2'd0, 1'b1, 1'b0, err};
        if (pl >= 32768) begin
            sig = pl / 256; rem = pl % 256; half = 128; norm = 1;
        end else begin
            sig = pl / 128; rem = pl % 128; half = 64; norm = 0;
        end
        if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
        ovf = (sig == 256) ? 1 : 0;
        if (ovf == 1) sig = 128;
        e = norm + ovf;
        return {sig[7:0], e[1:0], 1'b0, (rem != 0), err};
    endfunction

    task automatic gen_pair(output logic [17:0] s, output logic [17:0] c);
        int unsigned p, mode;
        mode = $urandom_range(0, 9);
        if (mode == 0)      p = $urandom_range(0, 262143);
        else if (mode == 1) p = 0;
        else                p = $urandom_range(16384, 65535);
        s = 18'($urandom);
        c = 18'(p - int'(s));
    endtask

    // Apply inputs just after a rising edge; they are sampled by the next one.
    task automatic drive(input logic rst, input logic v, input logic [17:0] s,
                         input logic [17:0] c, input logic r);
        @(posedge CLK);
        #1;
        RST = rst; in_valid = v; in_sum = s; in_carry = c; out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] s, c;
        for (int k = 0; k < 2; k++) begin
            gen_pair(s, c);
            drive(1'b1, 1'b1, s, c, 1'b1);
        end
        drive(1'b1, 1'b1, 18'h04000, 18'h0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (observed() !== 13'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0000", observed());
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b1);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle cyc %0d got valid=%b ready=%b want 0/1", k, out_valid, in_ready);
            end
        end
        $display("reset: checked idle state");
    endtask

    task automatic test_directed();
        logic [17:0] d_sum[10] = '{18'h04000, 18'h08000, 18'h03FC0, 18'h04040, 18'h040C0,
                                   18'h00000, 18'h10000, 18'h00180, 18'h04041, 18'h0FFFF};
        logic [17:0] d_car[10] = '{18'h0, 18'h04000, 18'h04000, 18'h0, 18'h0,
                                   18'h0, 18'h0, 18'h03E80, 18'h0, 18'h0};
        logic [12:0] d_exp[10] = '{{8'h80, 2'd0, 3'b000}, {8'hC0, 2'd1, 3'b000},
                                   {8'h80, 2'd1, 3'b010}, {8'h80, 2'd0, 3'b010},
                                   {8'h82, 2'd0, 3'b010}, {8'h00, 2'd0, 3'b100},
                                   {8'h00, 2'd0, 3'b101}, {8'h80, 2'd0, 3'b000},
                                   {8'h81, 2'd0, 3'b010}, {8'h80, 2'd2, 3'b010}};
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, d_sum[i], d_car[i], 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL directed_in_ready vec %0d got %b want 1", i, in_ready);
            end
            for (int k = 1; k <= 3; k++) begin
                drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b1);
                checks++;
                if (out_valid !== (k == 3)) begin
                    errors++;
                    $display("FAIL directed_latency vec %0d cyc %0d got valid=%b want %b", i, k, out_valid, (k == 3));
                end
            end
            checks++;
            if (observed() !== d_exp[i]) begin
                errors++;
                $display("FAIL directed_result vec %0d got %h want %h", i, observed(), d_exp[i]);
            end
            $display("directed %0d: sum=%h carry=%h -> sig=%h exp_inc=%0d zero=%b inexact=%b err=%b",
                     i, d_sum[i], d_car[i], out_sig, out_exp_inc, out_zero, out_inexact, out_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] s, c;
        logic [12:0] first;
        int delivered = 0;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            gen_pair(s, c);
            drive(1'b0, (k < 3), s, c, !(k >= 3 && k <= 6));
            if (k == 3) first = exp_q[0];
            if (k >= 3 && k <= 6) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready cyc %0d got %b want 0", k, in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || observed() !== first) begin
                    errors++;
                    $display("FAIL stall_frozen cyc %0d got valid=%b res=%h want 1/%h", k, out_valid, observed(), first);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra cyc %0d got %h want none", k, observed());
                end else begin
                    if (observed() !== exp_q[0]) begin
                        errors++; $display("FAIL b2b_order cyc %0d got %h want %h", k, observed(), exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                delivered++;
                $display("b2b: delivered %0d sig=%h exp_inc=%0d", delivered, out_sig, out_exp_inc);
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_carry));
        end
        checks++;
        if (delivered != 3 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d pending %0d want 3 pending 0", delivered, exp_q.size());
        end
    endtask

    task automatic test_reset_flight();
        logic [17:0] s, c;
        for (int k = 0; k < 2; k++) begin
            gen_pair(s, c);
            drive(1'b0, 1'b1, s, c, 1'b1);
        end
        drive(1'b1, 1'b1, 18'h04000, 18'h0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flight_in_ready got %b want 1", in_ready);
        end
        drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flight_reset_valid got %b want 0", out_valid);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 18'h0, 18'h0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flight_ghost cyc %0d got valid=%b want 0", k, out_valid);
            end
        end
        $display("reset_flight: two in-flight results discarded");
    endtask

    task automatic test_random();
        logic [17:0] s, c;
        logic [12:0] held;
        logic        stalled = 1'b0;
        int          n = 0;
        exp_q.delete();
        for (int k = 0; k < 520; k++) begin
            gen_pair(s, c);
            if (k < 500) drive(1'b0, ($urandom_range(0, 3) != 0), s, c, ($urandom_range(0, 3) != 0));
            else         drive(1'b0, 1'b0, s, c, 1'b1);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready cyc %0d got %b want %b", k, in_ready, (!out_valid || out_ready));
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || observed() !== held) begin
                    errors++;
                    $display("FAIL rand_hold cyc %0d got valid=%b res=%h want 1/%h", k, out_valid, observed(), held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = observed();
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra cyc %0d got %h want none", k, observed());
                end else begin
                    if (observed() !== exp_q[0]) begin
                        errors++; $display("FAIL rand_result txn %0d got %h want %h", n, observed(), exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                $display("random txn %0d: sig=%h exp_inc=%0d zero=%b inexact=%b err=%b",
                         n, out_sig, out_exp_inc, out_zero, out_inexact, out_err);
                n++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_carry));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
